// File: rtl/uart_rx_flagged_if.sv
// Bundle between the UART receiver and the crypter stage.
// Handshake: `ready` is the valid flag for `data_out`/`eot`.
// It stays high until the consumer pulses `clear_flag` for one cycle,
// and it drops on the following edge.
// If a new byte lands while `ready` is still high and no acknowledge is
// given in that cycle, `overrun` is raised and the old byte is replaced.
// `state_dbg` exposes the receiver FSM for observation.
interface uart_rx_flagged_if;
    logic       rx;
    logic       clear_flag;
    logic [7:0] data_out;
    logic       ready;
    logic       eot;
    logic       overrun;
    logic       frame_err;
    logic [2:0] state_dbg;

    modport master (
        output rx, clear_flag,
        input  data_out, ready, eot, overrun, frame_err, state_dbg
    );

    modport slave (
        input  rx, clear_flag,
        output data_out, ready, eot, overrun, frame_err, state_dbg
    );
endinterface

// File: rtl/uart_rx_flagged.sv
// 8N1 UART receiver with 16x oversampling and a flag-protected output byte.
// Error flags (overrun, frame_err) are sticky until acknowledged.
module uart_rx_flagged #(
    parameter int         TICK_DIV = 54,
    parameter logic [7:0] EOT_CHAR = 8'h04
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_flagged_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    localparam int            TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    logic          rx_meta, rx_s;
    logic [TW-1:0] tick_cnt;
    logic          s_tick;
    state_t        state_q, state_d;
    logic [3:0]    s_cnt_q, s_cnt_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          commit, stop_err;
    logic [7:0]    data_q;
    logic          ready_q, eot_q, overrun_q, frame_err_q;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk) begin
        if (rst || s_tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 1'b1;
    end

    assign s_tick = (tick_cnt == TICK_MAX);

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_q     <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
        end
    end

    // Next state: mid-start check at tick 7, then one sample every 16 ticks.
    always_comb begin
        state_d  = state_q;
        s_cnt_d  = s_cnt_q;
        n_d      = n_q;
        shreg_d  = shreg_q;
        commit   = 1'b0;
        stop_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == 4'd15) begin
                        shreg_d = {rx_s, shreg_q[7:1]};
                        s_cnt_d = '0;
                        if (n_q == 3'd7) state_d = STOP;
                        else             n_d     = n_q + 3'd1;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == 4'd15) begin
                        s_cnt_d = '0;
                        if (rx_s) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            stop_err = 1'b1;
                            state_d  = WAIT_HIGH;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line is released so a break is not a new start.
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output flags: acknowledge clears first, a same-cycle commit or error wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            ready_q     <= 1'b0;
            eot_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (bus.clear_flag) begin
                ready_q     <= 1'b0;
                eot_q       <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (commit) begin
                data_q  <= shreg_q;
                ready_q <= 1'b1;
                eot_q   <= (shreg_q == EOT_CHAR);
                if (ready_q && !bus.clear_flag) overrun_q <= 1'b1;
            end
            if (stop_err) frame_err_q <= 1'b1;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.ready     = ready_q;
    assign bus.eot       = eot_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: doc/uart_rx_flagged.md
# uart_rx_flagged

Serial receiver that feeds the crypter stage. Deserialises 8N1 UART frames from the `rx` pin and holds each byte in a flag-protected output register. `ready` stays set until the crypter acknowledges with `clear_flag`; `eot` marks the end-of-transmission character. Overrun and framing errors are latched for debug LEDs.

## Interface
Parameters:
- `TICK_DIV`, 54: clock cycles per oversample tick. 100 MHz / (16 × 115200) ≈ 54.
- `EOT_CHAR`, 8'h04: byte value that sets `eot`.

Ports (clock and reset first):
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `clear_flag`  in  1  one-cycle acknowledge from the crypter. Clears `ready`, `eot`, `overrun`, `frame_err`.
- `data_out`  out  8  last correctly framed byte.
- `ready`  out  1  new byte available (sticky).
- `eot`  out  1  latched byte equals `EOT_CHAR`. Valid only while `ready`=1.
- `overrun`  out  1  a byte was committed while `ready` was still set (sticky).
- `frame_err`  out  1  stop bit sampled low (sticky).

## Operation
- **Input synchroniser:** `rx` passes through a 2-FF synchroniser (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- **Tick generator:** free-running counter 0..`TICK_DIV`-1. Emits a 1-cycle `s_tick` on wrap.
- **Counters:**
  - `s_cnt`, 4 bits: counts ticks within a bit.
  - `n`, 3 bits: data-bit index.
  - `shreg`, 8 bits: right-shift register; LSB arrives first, shifted in at bit 7.
- **FSM states:**
  - `IDLE`: when `rx_s`=0, go to `START` with `s_cnt`=0.
  - `START`: count ticks. At `s_cnt`=7 (mid start bit):
    - if `rx_s`=0, go to `DATA` with `s_cnt`=0, `n`=0;
    - otherwise it was a glitch; go back to `IDLE`.
  - `DATA`: at `s_cnt`=15, shift `rx_s` into `shreg` and set `s_cnt`=0. After `n`=7 is sampled, go to `STOP`.
  - `STOP`: at `s_cnt`=15, sample `rx_s`:
    - 1: commit, then go to `IDLE`;
    - 0: set `frame_err`, discard the byte, go to `WAIT_HIGH`.
  - `WAIT_HIGH`: stay until `rx_s`=1, then go to `IDLE`. This prevents a line break from retriggering reception.
- **Commit:**
  - `data_out` ← `shreg`.
  - `ready` ← 1.
  - `eot` ← (`shreg` == `EOT_CHAR`).
  - If `ready` was already 1 and `clear_flag` is 0 in the same cycle, set `overrun`. The new byte overwrites the old one.
- **Simultaneous commit and `clear_flag`:** the clear applies to the old byte; the commit wins. Result: `ready`=1, `eot` reflects the new byte, `overrun`=0, `frame_err`=0.
- **`clear_flag` while `ready`=0:** clears only the error flags. Harmless.
- **`clear_flag` has no effect on the FSM.** Reception continues.

## Timing
- **Reset values:**
  - `data_out`=0, `ready`=0, `eot`=0, `overrun`=0, `frame_err`=0.
  - FSM in `IDLE`; `rx_s`=1; all counters 0.
- **Reset mid-frame:** the partial byte is dropped with no flag change. The next valid frame is received normally.
- **Bit period:** 16 × `TICK_DIV` clocks. Sample points are mid-bit, ±1 tick of jitter, because the tick counter is free-running.
- **Latency:** `ready` rises 1 clk after the stop-bit sample tick. That is about 9.5 bit periods + 2 (synchroniser) + ≤`TICK_DIV` clocks after the start-bit falling edge at the pin.
- **Flag updates:**
  - `data_out`, `eot` and `ready` update in the same cycle.
  - `clear_flag` takes effect on the next edge, so flags read 0 one cycle after the acknowledge.
- **Minimum inter-frame gap:** none beyond the stop bit. The FSM re-arms in `IDLE` on the cycle after the stop sample.

## Test plan
All scenarios use `TICK_DIV`=4, i.e. bit = 64 clk.
1. Frame 0x68 → `ready`=1, `data_out`=0x68, `eot`=0 within 640 clk of the start edge. Pulse `clear_flag` → `ready`=0 on the next cycle.
2. Frame 0x04 → `ready`=1, `eot`=1, `data_out`=0x04. `clear_flag` → `ready`=`eot`=0.
3. Frames 0x65 then 0x6C back-to-back, no clear → `data_out`=0x6C, `overrun`=1, `ready`=1. `clear_flag` pulsed exactly on the second commit cycle → `overrun`=0.
4. Frame 0xA5 with stop bit 0, line then held low for 3 bit times, then released → `frame_err`=1, `ready`=0, `data_out` unchanged. A following frame 0x11 → `data_out`=0x11.
5. Low glitch of 12 clk on an idle line → no `ready`, no error, FSM back in `IDLE`. A following frame 0x77 is received correctly.
6. `rst` pulsed during data bit 4 of frame 0x3C → all outputs 0. The next frame 0x21 is received, `ready`=1, `data_out`=0x21.
